// File: rtl/data_mem_responder.sv
// Data-memory responder for the LSU req/gnt/rvalid handshake.
// Grants requests after an optional stall, applies writes with byte enables,
// and returns one in-order response per accepted transaction after a fixed
// latency. Addresses beyond the array answer with an error flag.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int GNT_STALL   = 0,
    parameter int RD_LATENCY  = 1,
    parameter int MAX_OUTST   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int STALL_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;
    localparam int OUTST_W = $clog2(MAX_OUTST + 1);

    localparam logic [29:0]        DEPTH_L   = 30'(DEPTH_WORDS);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(GNT_STALL);
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);
    localparam logic [31:0]        OOR_DATA  = 32'hDEAD_BEEF;

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $error("data_mem_responder: RD_LATENCY must be within 1..8");
    end
    if (MAX_OUTST < 1) begin : g_bad_outst
        $error("data_mem_responder: MAX_OUTST must be at least 1");
    end

    logic [31:0]        mem [DEPTH_WORDS];

    logic [STALL_W-1:0] stall_cnt;
    logic [OUTST_W-1:0] outst;

    logic [29:0]        word_addr;
    logic [IDX_W-1:0]   word_idx;
    logic               in_range;
    logic               accept;
    logic [31:0]        rd_word;

    logic               stage_valid;
    logic               stage_err;
    logic [31:0]        stage_data;

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_err;
    logic [31:0]           pipe_data [RD_LATENCY];

    logic               unused_addr_lsbs;

    // Byte offset within the word carries no meaning for a word-wide memory.
    assign unused_addr_lsbs = ^data_addr_i[1:0];

    assign word_addr = data_addr_i[31:2];
    assign word_idx  = word_addr[IDX_W-1:0];
    assign in_range  = (word_addr < DEPTH_L);

    // Grant is held off during reset so nothing can be accepted while the
    // stall counter and response pipe are being cleared. The registered
    // outstanding count is used, so a response leaving this cycle does not
    // open a slot until the next one.
    assign data_gnt_o = data_req_i & ~rst
                      & (stall_cnt == STALL_MAX)
                      & (outst < OUTST_MAX);
    assign accept     = data_gnt_o;

    // Counts cycles a request has waited ungranted; restarts when it is
    // accepted or withdrawn, and keeps counting while blocked by outst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (data_req_i && !accept) begin
            if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // Tracks accepted transactions whose response has not yet been issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst <= '0;
        end else begin
            case ({accept, data_rvalid_o})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Builds the response for the transaction being accepted this cycle;
    // write responses carry zero data, out-of-range reads a marker pattern.
    always_comb begin
        rd_word     = mem[word_idx];
        stage_valid = accept;
        stage_err   = 1'b0;
        stage_data  = '0;
        if (accept) begin
            if (!in_range) begin
                stage_err  = 1'b1;
                stage_data = data_we_i ? 32'h0 : OOR_DATA;
            end else if (!data_we_i) begin
                stage_data = rd_word;
            end
        end
    end

    // Fixed-latency response shift register; empty slots hold zero data so
    // rdata reads as zero whenever rvalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= stage_valid;
            pipe_err[0]   <= stage_err;
            pipe_data[0]  <= stage_data;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_valid[RD_LATENCY-1];
    assign data_err_o    = pipe_err[RD_LATENCY-1];
    assign data_rdata_o  = pipe_data[RD_LATENCY-1];

endmodule
